display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 100000000, message display time in clk cycles (legal range 1..2^CNT_W-1).
REQ-002 SHALL have parameter BLINK_HALF, default 25000000, blink half-period in clk cycles (legal range 1..2^CNT_W-1).
REQ-003 SHALL have parameter CNT_W, default 27, width of the hold and blink counters.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port base_digits  input  16  normal display word {dig3,dig2,dig1,dig0}.
REQ-007 SHALL have port blink_mask  input  4  per-digit blink enable for base source, bit i = dig i.
REQ-008 SHALL have port msg_req  input  1  level request to show a timed message.
REQ-009 SHALL have port msg_digits  input  16  message word, sampled only on accept.
REQ-010 SHALL have port alert_active  input  1  level; high-priority alert present.
REQ-011 SHALL have port alert_digits  input  16  alert word, live (not latched).
REQ-012 SHALL have port digits  output  16  registered word to the 7-segment display controller.
REQ-013 SHALL have port blank  output  4  registered per-digit blank, 1 = digit off.
REQ-014 SHALL have port msg_ack  output  1  one-cycle pulse: message accepted.
REQ-015 SHALL have port msg_done  output  1  one-cycle pulse: message hold completed.
REQ-016 SHALL have port msg_abort  output  1  one-cycle pulse: message preempted by alert.

Function
REQ-017 SHALL implement FSM states SHOW_BASE, SHOW_MSG, SHOW_ALERT; priority alert > message > base.
REQ-018 SHALL, in any state with alert_active=1, enter SHOW_ALERT at the next edge; from SHOW_MSG also pulse msg_abort on that edge, with no msg_done.
REQ-019 SHALL, in SHOW_BASE with msg_req=1 and alert_active=0, at the next edge latch msg_digits, pulse msg_ack, load hold counter with HOLD_CYCLES-1, and enter SHOW_MSG.
REQ-020 SHALL, in SHOW_MSG, decrement the hold counter each cycle; with counter=0 and alert_active=0, enter SHOW_BASE and pulse msg_done on that edge (message shown exactly HOLD_CYCLES cycles at digits).
REQ-021 SHALL ignore msg_req while in SHOW_MSG or SHOW_ALERT; a held msg_req is accepted by REQ-019 no earlier than the first cycle back in SHOW_BASE.
REQ-022 SHALL leave SHOW_ALERT for SHOW_BASE at the first edge with alert_active=0; an aborted message is not resumed.
REQ-023 SHALL register digits every cycle from the current state's source (base_digits / latched message / alert_digits): 1-cycle latency from state and from input change.
REQ-024 SHALL run a free-running blink counter wrapping at BLINK_HALF-1 and toggle blink_phase on each wrap.
REQ-025 SHALL register blank = blink_mask & {4{blink_phase}} in SHOW_BASE and 4'b0000 in other states.
REQ-026 SHALL never assert more than one of msg_ack, msg_done, msg_abort in a cycle.

Reset
REQ-027 SHALL, while rst_n=0, force state SHOW_BASE, digits=16'h0000, blank=4'b0000, msg_ack=msg_done=msg_abort=0, hold and blink counters=0, blink_phase=0, latched message=16'h0000.
REQ-028 SHALL, on reset mid-message, abandon the message with no msg_done or msg_abort pulse.

Configuration
REQ-029 SHALL, with DISPLAY_SCHEDULER_BLINK_EN defined, implement REQ-024/REQ-025; without it, omit the blink counter, tie blank to 4'b0000, and ignore blink_mask.

Verification (HOLD_CYCLES=4, BLINK_HALF=3, BLINK_EN defined)
REQ-030 SHALL cover: base_digits=16'h1234, no requests -> digits=16'h1234 one cycle later, no pulses.
REQ-031 SHALL cover: msg_req 1 cycle, msg_digits=16'hBEEF -> msg_ack next edge, digits=16'hBEEF for exactly 4 cycles, msg_done pulse, then digits=base.
REQ-032 SHALL cover: alert_active=1 (alert_digits=16'hEEEE) during message cycle 2 -> msg_abort pulse, digits=16'hEEEE, no msg_done; alert deasserted -> base restored.
REQ-033 SHALL cover: msg_req and alert_active rise together in SHOW_BASE -> SHOW_ALERT, no msg_ack until alert clears, then msg_ack.
REQ-034 SHALL cover: blink_mask=4'b0101 in SHOW_BASE -> blank alternates 4'b0000/4'b0101 every 3 cycles; blank=0 during message.
REQ-035 SHALL cover: rst_n low mid-message -> all outputs 0 asynchronously, SHOW_BASE after release, no pulses.

Source files
------------

// File: rtl/display_scheduler.sv
// Display source scheduler: alert > timed message > base word, with registered outputs.
// Per-digit blink of the base word is compiled in only when DISPLAY_SCHEDULER_BLINK_EN is defined.
module display_scheduler #(
   parameter int unsigned HOLD_CYCLES = 100000000,
   parameter int unsigned BLINK_HALF  = 25000000,
   parameter int unsigned CNT_W       = 27
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] base_digits,
   input  logic [3:0]  blink_mask,
   input  logic        msg_req,
   input  logic [15:0] msg_digits,
   input  logic        alert_active,
   input  logic [15:0] alert_digits,
   output logic [15:0] digits,
   output logic [3:0]  blank,
   output logic        msg_ack,
   output logic        msg_done,
   output logic        msg_abort
);

   typedef enum logic [1:0] {
      SHOW_BASE  = 2'd0,
      SHOW_MSG   = 2'd1,
      SHOW_ALERT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] hold_r;
   logic [CNT_W-1:0] hold_s;
   logic [15:0]      msg_r;
   logic [15:0]      msg_s;
   logic             ack_s;
   logic             done_s;
   logic             abort_s;
   logic [15:0]      digits_s;
   logic [3:0]       blank_s;
   logic [15:0]      digits_r;
   logic [3:0]       blank_r;
   logic             ack_r;
   logic             done_r;
   logic             abort_r;

   // Next-state, hold counter and event pulses; alert always wins over message timeout.
   always_comb begin
      state_s = state_r;
      hold_s  = hold_r;
      msg_s   = msg_r;
      ack_s   = 1'b0;
      done_s  = 1'b0;
      abort_s = 1'b0;
      case (state_r)
         SHOW_BASE: begin
            if (alert_active) begin
               state_s = SHOW_ALERT;
            end else if (msg_req) begin
               state_s = SHOW_MSG;
               msg_s   = msg_digits;
               hold_s  = HOLD_LOAD;
               ack_s   = 1'b1;
            end else begin
               state_s = SHOW_BASE;
            end
         end
         SHOW_MSG: begin
            if (alert_active) begin
               state_s = SHOW_ALERT;
               abort_s = 1'b1;
            end else if (hold_r == CNT_ZERO) begin
               state_s = SHOW_BASE;
               done_s  = 1'b1;
            end else begin
               hold_s = hold_r - CNT_ONE;
            end
         end
         SHOW_ALERT: begin
            if (alert_active) begin
               state_s = SHOW_ALERT;
            end else begin
               state_s = SHOW_BASE;
            end
         end
         default: begin
            state_s = SHOW_BASE;
         end
      endcase
   end

   // Digit source follows the current state, so the display lags the state by one cycle.
   always_comb begin
      digits_s = base_digits;
      case (state_r)
         SHOW_BASE:  digits_s = base_digits;
         SHOW_MSG:   digits_s = msg_r;
         SHOW_ALERT: digits_s = alert_digits;
         default:    digits_s = 16'h0000;
      endcase
   end

`ifdef DISPLAY_SCHEDULER_BLINK_EN
   localparam logic [CNT_W-1:0] BLINK_WRAP = CNT_W'(BLINK_HALF - 1);

   logic [CNT_W-1:0] blink_cnt_r;
   logic             blink_phase_r;

   // Free-running half-period counter; phase flips on each wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_r   <= CNT_ZERO;
         blink_phase_r <= 1'b0;
      end else if (blink_cnt_r == BLINK_WRAP) begin
         blink_cnt_r   <= CNT_ZERO;
         blink_phase_r <= ~blink_phase_r;
      end else begin
         blink_cnt_r   <= blink_cnt_r + CNT_ONE;
      end
   end

   // Blinking applies only to the base word.
   always_comb begin
      blank_s = 4'b0000;
      if (state_r == SHOW_BASE) begin
         blank_s = blink_mask & {4{blink_phase_r}};
      end else begin
         blank_s = 4'b0000;
      end
   end
`else
   logic unused_blink_mask_s;
   assign unused_blink_mask_s = ^blink_mask;

   // Without blink support every digit stays lit.
   always_comb begin
      blank_s = 4'b0000;
   end
`endif

   // State, counters and all outputs are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= SHOW_BASE;
         hold_r   <= CNT_ZERO;
         msg_r    <= 16'h0000;
         digits_r <= 16'h0000;
         blank_r  <= 4'b0000;
         ack_r    <= 1'b0;
         done_r   <= 1'b0;
         abort_r  <= 1'b0;
      end else begin
         state_r  <= state_s;
         hold_r   <= hold_s;
         msg_r    <= msg_s;
         digits_r <= digits_s;
         blank_r  <= blank_s;
         ack_r    <= ack_s;
         done_r   <= done_s;
         abort_r  <= abort_s;
      end
   end

   assign digits    = digits_r;
   assign blank     = blank_r;
   assign msg_ack   = ack_r;
   assign msg_done  = done_r;
   assign msg_abort = abort_r;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed self-checking bench for display_scheduler with HOLD_CYCLES=4, BLINK_HALF=3.
module tb_display_scheduler;

   logic        clk;
   logic        rst_n;
   logic [15:0] base_digits;
   logic [3:0]  blink_mask;
   logic        msg_req;
   logic [15:0] msg_digits;
   logic        alert_active;
   logic [15:0] alert_digits;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic        msg_ack;
   logic        msg_done;
   logic        msg_abort;

   int n_checks = 0;
   int n_errors = 0;

   display_scheduler #(
      .HOLD_CYCLES(4),
      .BLINK_HALF (3),
      .CNT_W      (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .base_digits (base_digits),
      .blink_mask  (blink_mask),
      .msg_req     (msg_req),
      .msg_digits  (msg_digits),
      .alert_active(alert_active),
      .alert_digits(alert_digits),
      .digits      (digits),
      .blank       (blank),
      .msg_ack     (msg_ack),
      .msg_done    (msg_done),
      .msg_abort   (msg_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, sample just after it, and confirm the pulses are mutually exclusive.
   task automatic tick();
      @(posedge clk);
      #1;
      check_value("pulse_onehot", {31'd0, (32'(msg_ack) + 32'(msg_done) + 32'(msg_abort)) <= 32'd1}, 32'd1);
   endtask

   task automatic check_pulses(input string tag, input logic a, input logic d, input logic ab);
      check_value(tag, {29'd0, msg_ack, msg_done, msg_abort}, {29'd0, a, d, ab});
   endtask

   logic [3:0] exp_blank [9];

   initial begin
`ifdef DISPLAY_SCHEDULER_BLINK_EN
      exp_blank = '{4'h0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0};
`else
      exp_blank = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`endif
      rst_n        = 1'b0;
      base_digits  = 16'h0000;
      blink_mask   = 4'b0000;
      msg_req      = 1'b0;
      msg_digits   = 16'h0000;
      alert_active = 1'b0;
      alert_digits = 16'h0000;

      // Reset state with live inputs applied
      repeat (2) @(posedge clk);
      #1;
      base_digits = 16'h1234;
      blink_mask  = 4'b0101;
      @(posedge clk);
      #1;
      check_value("rst_digits", {16'd0, digits}, 32'h0);
      check_value("rst_blank", {28'd0, blank}, 32'h0);
      check_pulses("rst_pulses", 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Base display and blink pattern
      for (int k = 0; k < 9; k++) begin
         tick();
         check_value($sformatf("blink_e%0d", k + 1), {28'd0, blank}, {28'd0, exp_blank[k]});
         check_value("base_digits", {16'd0, digits}, 32'h1234);
         check_pulses("base_pulses", 1'b0, 1'b0, 1'b0);
      end

      // Timed message shown for exactly four cycles
      msg_req    = 1'b1;
      msg_digits = 16'hBEEF;
      tick();
      check_pulses("msg_ack", 1'b1, 1'b0, 1'b0);
      check_value("msg_latency", {16'd0, digits}, 32'h1234);
      msg_req    = 1'b0;
      msg_digits = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_value($sformatf("msg_digits_c%0d", i), {16'd0, digits}, 32'hBEEF);
         check_value("msg_blank", {28'd0, blank}, 32'h0);
         check_pulses($sformatf("msg_pulses_c%0d", i), 1'b0, (i == 3), 1'b0);
      end
      tick();
      check_value("msg_back_base", {16'd0, digits}, 32'h1234);
      check_pulses("msg_after_done", 1'b0, 1'b0, 1'b0);

      // Alert preempts the message during its second cycle
      msg_req      = 1'b1;
      msg_digits   = 16'hCAFE;
      alert_digits = 16'hEEEE;
      tick();
      check_pulses("abort_ack", 1'b1, 1'b0, 1'b0);
      msg_req = 1'b0;
      tick();
      check_value("abort_msg_c1", {16'd0, digits}, 32'hCAFE);
      alert_active = 1'b1;
      tick();
      check_pulses("abort_pulse", 1'b0, 1'b0, 1'b1);
      check_value("abort_msg_c2", {16'd0, digits}, 32'hCAFE);
      tick();
      check_value("alert_digits", {16'd0, digits}, 32'hEEEE);
      check_value("alert_blank", {28'd0, blank}, 32'h0);
      check_pulses("alert_quiet", 1'b0, 1'b0, 1'b0);
      alert_digits = 16'h5555;
      tick();
      check_value("alert_live", {16'd0, digits}, 32'h5555);
      tick();
      check_pulses("alert_no_done", 1'b0, 1'b0, 1'b0);
      alert_active = 1'b0;
      tick();
      check_value("alert_exit_lag", {16'd0, digits}, 32'h5555);
      tick();
      check_value("alert_base_restored", {16'd0, digits}, 32'h1234);
      check_pulses("alert_no_resume", 1'b0, 1'b0, 1'b0);

      // Request and alert together; held request then accepted once back in base
      msg_req      = 1'b1;
      msg_digits   = 16'h7777;
      alert_active = 1'b1;
      alert_digits = 16'hAAAA;
      tick();
      check_pulses("both_no_ack1", 1'b0, 1'b0, 1'b0);
      tick();
      check_value("both_alert", {16'd0, digits}, 32'hAAAA);
      check_pulses("both_no_ack2", 1'b0, 1'b0, 1'b0);
      alert_active = 1'b0;
      tick();
      check_pulses("both_no_ack3", 1'b0, 1'b0, 1'b0);
      tick();
      check_pulses("both_ack", 1'b1, 1'b0, 1'b0);
      tick();
      check_value("both_msg", {16'd0, digits}, 32'h7777);
      repeat (2) tick();
      check_pulses("held_req_ignored", 1'b0, 1'b0, 1'b0);
      tick();
      check_pulses("held_done", 1'b0, 1'b1, 1'b0);
      tick();
      check_pulses("held_reaccept", 1'b1, 1'b0, 1'b0);
      msg_req = 1'b0;
      tick();
      check_value("held_msg", {16'd0, digits}, 32'h7777);

      // Asynchronous reset in the middle of a message
      #2;
      rst_n = 1'b0;
      #1;
      check_value("arst_digits", {16'd0, digits}, 32'h0);
      check_value("arst_blank", {28'd0, blank}, 32'h0);
      check_pulses("arst_pulses", 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_value("arst_hold", {16'd0, digits}, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_value("arst_base", {16'd0, digits}, 32'h1234);
         check_pulses("arst_no_pulse", 1'b0, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
